// File: rtl/scroll_display_n.sv
// Multiplexed 7-segment marquee: scans NUM_DIGITS digits out of a writable message buffer
// and slides the visible window by one entry on every scroll step.
module scroll_display_n #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned MSG_DEPTH   = 16,
   parameter int unsigned REFRESH_DIV = 200000,
   parameter int unsigned STEP_DIV    = 200000000
) (
   input  logic                         fastclk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
   input  logic [7:0]                   wr_data,
   input  logic [$clog2(MSG_DEPTH):0]   msg_len,
   input  logic                         enable,
   input  logic                         dir,
   input  logic                         blank,
   output logic [NUM_DIGITS-1:0]        select,
   output logic [7:0]                   hex_display,
   output logic [$clog2(MSG_DEPTH)-1:0] pos,
   output logic                         step_pulse
);

   localparam int unsigned AW      = $clog2(MSG_DEPTH);
   localparam int unsigned LW      = AW + 1;
   localparam int unsigned MemSize = 1 << AW;
   localparam int unsigned SW      = $clog2(NUM_DIGITS);
   localparam int unsigned RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned TW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [RW-1:0]         RefMax  = RW'(REFRESH_DIV - 1);
   localparam logic [TW-1:0]         StepMax = TW'(STEP_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] LeftSel = {1'b1, {(NUM_DIGITS - 1){1'b0}}};

   // Sized to the full address space so any pointer value reads a defined entry;
   // entries at or beyond MSG_DEPTH are never written and stay zero.
   logic [7:0]            mem_q [MemSize];
   logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
   logic [TW-1:0]         step_cnt_q, step_cnt_d;
   logic [SW-1:0]         scan_idx_q, scan_idx_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         pos_q, pos_d;
   logic [NUM_DIGITS-1:0] select_q, select_d;
   logic [7:0]            hex_q, hex_d;
   logic                  pulse_q;

   logic [LW-1:0] eff_len;
   logic [LW-1:0] cur_inc;
   logic [AW-1:0] cur;
   logic [AW-1:0] last_idx;
   logic          ref_tick;
   logic          step_tick;
   logic          wr_ok;

   if (MemSize == MSG_DEPTH) begin : g_full_addr
      assign wr_ok = 1'b1;
   end else begin : g_part_addr
      assign wr_ok = ({1'b0, wr_addr} < LW'(MSG_DEPTH));
   end

   always_comb begin
      eff_len   = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
      last_idx  = AW'(eff_len - LW'(1));
      ref_tick  = (ref_cnt_q == RefMax);
      step_tick = enable && (step_cnt_q == StepMax);
      // Digit 0 re-anchors the frame on pos; later digits follow the read pointer.
      cur       = (scan_idx_q == '0) ? pos_q : rd_ptr_q;
      cur_inc   = {1'b0, cur} + LW'(1);

      ref_cnt_d  = ref_tick ? '0 : ref_cnt_q + RW'(1);
      step_cnt_d = step_cnt_q;
      if (enable) begin
         step_cnt_d = step_tick ? '0 : step_cnt_q + TW'(1);
      end

      // A shrunken message pulls the offset back in range before any step applies.
      pos_d = pos_q;
      if ({1'b0, pos_q} >= eff_len) begin
         pos_d = '0;
      end else if (step_tick) begin
         if (dir) begin
            pos_d = (pos_q == '0) ? last_idx : pos_q - AW'(1);
         end else begin
            pos_d = (({1'b0, pos_q} + LW'(1)) == eff_len) ? '0 : pos_q + AW'(1);
         end
      end

      rd_ptr_d = rd_ptr_q;
      if ({1'b0, rd_ptr_q} >= eff_len) begin
         rd_ptr_d = '0;
      end else if (ref_tick) begin
         rd_ptr_d = (cur_inc == eff_len) ? '0 : cur_inc[AW-1:0];
      end

      select_d   = select_q;
      hex_d      = hex_q;
      scan_idx_d = scan_idx_q;
      if (ref_tick) begin
         select_d   = LeftSel >> scan_idx_q;
         hex_d      = (blank || (eff_len == '0)) ? 8'h00 : mem_q[cur];
         scan_idx_d = (scan_idx_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + SW'(1);
      end
   end

   always_ff @(posedge fastclk) begin
      if (reset) begin
         for (int i = 0; i < MemSize; i++) begin
            mem_q[i] <= 8'h00;
         end
         ref_cnt_q  <= '0;
         step_cnt_q <= '0;
         scan_idx_q <= '0;
         rd_ptr_q   <= '0;
         pos_q      <= '0;
         select_q   <= '0;
         hex_q      <= '0;
         pulse_q    <= 1'b0;
      end else begin
         if (wr_en && wr_ok) begin
            mem_q[wr_addr] <= wr_data;
         end
         ref_cnt_q  <= ref_cnt_d;
         step_cnt_q <= step_cnt_d;
         scan_idx_q <= scan_idx_d;
         rd_ptr_q   <= rd_ptr_d;
         pos_q      <= pos_d;
         select_q   <= select_d;
         hex_q      <= hex_d;
         pulse_q    <= step_tick;
      end
   end

   assign select      = select_q;
   assign hex_display = hex_q;
   assign pos         = pos_q;
   assign step_pulse  = pulse_q;

endmodule

// File: tb/tb_scroll_display_n.sv
// Directed bench for scroll_display_n with short refresh/step dividers and a
// non-power-of-two message depth.
module tb_scroll_display_n;

   localparam int unsigned NumDigits  = 4;
   localparam int unsigned MsgDepth   = 12;
   localparam int unsigned RefreshDiv = 2;
   localparam int unsigned StepDiv    = 16;

   logic       fastclk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [4:0] msg_len;
   logic       enable;
   logic       dir;
   logic       blank;
   logic [3:0] select;
   logic [7:0] hex_display;
   logic [3:0] pos;
   logic       step_pulse;

   int checks = 0;
   int errors = 0;
   int n;
   int pulses;
   int moved;

   always #5 fastclk = ~fastclk;

   scroll_display_n #(
      .NUM_DIGITS (NumDigits),
      .MSG_DEPTH  (MsgDepth),
      .REFRESH_DIV(RefreshDiv),
      .STEP_DIV   (StepDiv)
   ) dut (
      .fastclk    (fastclk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .msg_len    (msg_len),
      .enable     (enable),
      .dir        (dir),
      .blank      (blank),
      .select     (select),
      .hex_display(hex_display),
      .pos        (pos),
      .step_pulse (step_pulse)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step_n(input int cnt);
      repeat (cnt) @(negedge fastclk);
   endtask

   task automatic write_msg(input logic [3:0] addr, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      @(negedge fastclk);
      wr_en   = 1'b0;
   endtask

   // Lands on the first cycle a fresh digit-0 output is visible.
   task automatic sync_frame(input string tag);
      int cnt;
      cnt = 0;
      while (select !== 4'b0001 && cnt < 40) begin
         @(negedge fastclk);
         cnt++;
      end
      while (select !== 4'b1000 && cnt < 40) begin
         @(negedge fastclk);
         cnt++;
      end
      check({tag, "_sync"}, 32'(select === 4'b1000), 32'd1);
   endtask

   task automatic check_frame(input string tag, input logic [31:0] frame);
      logic [3:0] e_sel;
      sync_frame(tag);
      for (int d = 0; d < 4; d++) begin
         if (d > 0) step_n(2);
         e_sel = 4'b1000 >> d;
         check($sformatf("%s_d%0d_sel", tag, d), 32'(select), 32'(e_sel));
         check($sformatf("%s_d%0d_hex", tag, d), 32'(hex_display), 32'(frame[31-8*d -: 8]));
      end
   endtask

   task automatic wait_pulse(input string tag, output int cnt);
      cnt = 0;
      do begin
         @(negedge fastclk);
         cnt++;
      end while (step_pulse !== 1'b1 && cnt < 64);
      check({tag, "_seen"}, 32'(step_pulse === 1'b1), 32'd1);
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      msg_len = '0;
      enable  = 1'b0;
      dir     = 1'b0;
      blank   = 1'b0;
      step_n(3);
      check("rst_select", 32'(select), 32'h0);
      check("rst_hex", 32'(hex_display), 32'h0);
      check("rst_pos", 32'(pos), 32'h0);
      check("rst_pulse", 32'(step_pulse), 32'h0);

      // Scroll left through a six-entry message.
      reset   = 1'b0;
      msg_len = 5'd6;
      write_msg(4'd0, 8'hDA);
      write_msg(4'd1, 8'hFC);
      write_msg(4'd2, 8'h60);
      write_msg(4'd3, 8'hF6);
      write_msg(4'd4, 8'h66);
      write_msg(4'd5, 8'h7A);
      check_frame("f_pos0", 32'hDAFC60F6);
      enable = 1'b1;
      wait_pulse("p_first", n);
      check("p_first_latency", 32'(n), 32'd16);
      check("p_first_pos", 32'(pos), 32'd1);
      step_n(1);
      check("pulse_width", 32'(step_pulse), 32'd0);
      check_frame("f_pos1", 32'hFC60F666);
      repeat (4) wait_pulse("p_run", n);
      check("pos5", 32'(pos), 32'd5);
      check_frame("f_pos5", 32'h7ADAFC60);
      wait_pulse("p_wrap", n);
      check("wrap_pos", 32'(pos), 32'd0);

      // Reverse wraps to the end; an oversize length is clamped to the buffer depth.
      dir = 1'b1;
      wait_pulse("p_rev", n);
      check("rev_pos", 32'(pos), 32'd5);
      dir = 1'b0;
      wait_pulse("p_fwd", n);
      check("fwd_pos", 32'(pos), 32'd0);
      msg_len = 5'd31;
      dir     = 1'b1;
      wait_pulse("p_clamp", n);
      check("clamp_pos", 32'(pos), 32'd11);

      // Short message repeats; blank and zero length darken all digits.
      enable  = 1'b0;
      msg_len = 5'd2;
      dir     = 1'b0;
      step_n(1);
      check("shrink2_pos", 32'(pos), 32'd0);
      check_frame("f_len2", 32'hDAFCDAFC);
      blank = 1'b1;
      check_frame("f_blank", 32'h00000000);
      blank   = 1'b0;
      msg_len = 5'd0;
      check_frame("f_len0", 32'h00000000);

      // Pause mid-count, then resume with the remaining count.
      msg_len = 5'd6;
      enable  = 1'b1;
      wait_pulse("p_pre", n);
      check("p_pre_latency", 32'(n), 32'd16);
      check("p_pre_pos", 32'(pos), 32'd1);
      step_n(5);
      enable = 1'b0;
      pulses = 0;
      moved  = 0;
      repeat (40) begin
         @(negedge fastclk);
         if (step_pulse === 1'b1) pulses++;
         if (pos !== 4'd1) moved++;
      end
      enable = 1'b1;
      check("pause_pulses", 32'(pulses), 32'd0);
      check("pause_pos", 32'(moved), 32'd0);
      wait_pulse("p_resume", n);
      check("resume_latency", 32'(n), 32'd11);
      check("resume_pos", 32'(pos), 32'd2);

      // Shrink below pos, then write the entry read on the same edge.
      repeat (3) wait_pulse("p_to5", n);
      check("pos5_again", 32'(pos), 32'd5);
      enable  = 1'b0;
      msg_len = 5'd3;
      step_n(1);
      check("shrink3_pos", 32'(pos), 32'd0);
      sync_frame("f_wr");
      step_n(7);
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      wr_data = 8'h11;
      step_n(1);
      wr_en = 1'b0;
      check("wr_d0_sel", 32'(select), 32'h8);
      check("wr_d0_old", 32'(hex_display), 32'hDA);
      step_n(2);
      check("wr_d1_hex", 32'(hex_display), 32'hFC);
      step_n(2);
      check("wr_d2_hex", 32'(hex_display), 32'h60);
      step_n(2);
      check("wr_d3_sel", 32'(select), 32'h1);
      check("wr_d3_new", 32'(hex_display), 32'h11);
      step_n(2);
      check("wr_next_d0_sel", 32'(select), 32'h8);
      check("wr_next_d0_new", 32'(hex_display), 32'h11);

      // Reset mid-frame with blank asserted.
      step_n(3);
      reset = 1'b1;
      blank = 1'b1;
      step_n(1);
      check("mid_rst_select", 32'(select), 32'h0);
      check("mid_rst_hex", 32'(hex_display), 32'h0);
      check("mid_rst_pos", 32'(pos), 32'h0);
      check("mid_rst_pulse", 32'(step_pulse), 32'h0);
      reset = 1'b0;
      blank = 1'b0;
      n = 0;
      do begin
         @(negedge fastclk);
         n++;
      end while (select === 4'b0000 && n < 20);
      check("post_rst_latency", 32'(n), 32'(RefreshDiv));
      check("post_rst_sel", 32'(select), 32'h8);
      check("post_rst_hex", 32'(hex_display), 32'h0);
      check_frame("f_cleared", 32'h00000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
